// File: rtl/pci_pkg.sv
// Shared types for the PCI bus-master front end:
// FSM states, command codes and the released pad values.
package pci_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_TURN
  } state_t;

  localparam logic [3:0] MEM_READ  = 4'h6;
  localparam logic [3:0] MEM_WRITE = 4'h7;

  typedef struct packed {
    logic        req_n;
    logic        frame_n;
    logic        frame_oe;
    logic        irdy_n;
    logic        irdy_oe;
    logic [31:0] ad;
    logic        ad_oe;
    logic [3:0]  cbe_n;
    logic        cbe_oe;
  } bus_out_t;

  localparam bus_out_t BUS_IDLE = '{
    req_n:    1'b1,
    frame_n:  1'b1,
    frame_oe: 1'b0,
    irdy_n:   1'b1,
    irdy_oe:  1'b0,
    ad:       32'h0,
    ad_oe:    1'b0,
    cbe_n:    4'hF,
    cbe_oe:   1'b0
  };

endpackage

// File: rtl/pci_master_if_if.sv
// PCI segment signals seen by one bus master: arbiter
// handshake, FRAME#/IRDY#/TRDY#, AD and C/BE# with pad enables.
interface pci_master_if_if;

  logic        req_n;
  logic        gnt_n;
  logic        frame_in_n;
  logic        irdy_in_n;
  logic        trdy_n;
  logic        frame_n;
  logic        frame_oe;
  logic        irdy_n;
  logic        irdy_oe;
  logic [31:0] ad_out;
  logic [31:0] ad_in;
  logic        ad_oe;
  logic [3:0]  cbe_n;
  logic        cbe_oe;

  modport master (
    output req_n, frame_n, frame_oe,
    output irdy_n, irdy_oe,
    output ad_out, ad_oe, cbe_n, cbe_oe,
    input  gnt_n, frame_in_n, irdy_in_n,
    input  trdy_n, ad_in
  );

  modport slave (
    input  req_n, frame_n, frame_oe,
    input  irdy_n, irdy_oe,
    input  ad_out, ad_oe, cbe_n, cbe_oe,
    output gnt_n, frame_in_n, irdy_in_n,
    output trdy_n, ad_in
  );

endinterface

// File: rtl/pci_master_if.sv
// PCI bus-master front end: REQ#/GNT#, address and data phases.
// Optional TRDY# wait timeout with master abort: PCI_MASTER_TIMEOUT_EN.
module pci_master_if
  import pci_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
`ifdef PCI_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cmd,
  input  logic [31:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      wr_data,
  output logic             data_ack,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  pci_master_if_if.master  bus
);

  state_t           state;
  state_t           state_nx;
  bus_out_t         bo;
  logic [3:0]       cmd_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] remain;
  logic [LEN_W-1:0] len_c;
  logic             abort_q;
  logic             is_wr;
  logic             last;
  logic             fire;

  assign is_wr = cmd_q[0];
  assign last  = remain == LEN_W'(1);
  assign fire  = state == S_DATA
              && !bus.trdy_n
              && !abort_q;
  assign busy  = state != S_IDLE;

  always_comb begin
    len_c = len;
    unique case (1'b1)
      len == '0:              len_c = LEN_W'(1);
      len > LEN_W'(MAX_LEN):  len_c = LEN_W'(MAX_LEN);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_REQ;
      S_REQ:
        if (!bus.gnt_n && bus.frame_in_n
            && bus.irdy_in_n)
          state_nx = S_ADDR;
      S_ADDR: state_nx = S_DATA;
      S_DATA:
        if (abort_q || (fire && last))
          state_nx = S_TURN;
      S_TURN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bo = BUS_IDLE;
    unique case (state)
      S_REQ: bo.req_n = 1'b0;
      S_ADDR: begin
        bo.frame_n  = 1'b0;
        bo.frame_oe = 1'b1;
        bo.irdy_oe  = 1'b1;
        bo.ad       = addr_q;
        bo.ad_oe    = 1'b1;
        bo.cbe_n    = cmd_q;
        bo.cbe_oe   = 1'b1;
      end
      S_DATA: begin
        bo.frame_n  = last || abort_q;
        bo.frame_oe = 1'b1;
        bo.irdy_n   = 1'b0;
        bo.irdy_oe  = 1'b1;
        bo.ad       = is_wr ? wr_data : '0;
        bo.ad_oe    = is_wr;
        bo.cbe_n    = 4'h0;
        bo.cbe_oe   = 1'b1;
      end
      S_TURN: bo.irdy_oe = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_n    = bo.req_n;
  assign bus.frame_n  = bo.frame_n;
  assign bus.frame_oe = bo.frame_oe;
  assign bus.irdy_n   = bo.irdy_n;
  assign bus.irdy_oe  = bo.irdy_oe;
  assign bus.ad_out   = bo.ad;
  assign bus.ad_oe    = bo.ad_oe;
  assign bus.cbe_n    = bo.cbe_n;
  assign bus.cbe_oe   = bo.cbe_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      addr_q   <= '0;
      remain   <= '0;
      data_ack <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      data_ack <= fire;
      rd_valid <= fire && !is_wr;
      done     <= state == S_TURN;
      if (state == S_IDLE && start) begin
        cmd_q  <= cmd;
        addr_q <= addr;
        remain <= len_c;
      end
      if (fire) begin
        remain <= remain - LEN_W'(1);
        if (!is_wr) rd_data <= bus.ad_in;
      end
    end
  end

`ifdef PCI_MASTER_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT) + 1;

  logic [WT_W-1:0] wait_q;
  logic            err_q;

  // abort_q holds from the FRAME#-release cycle through TURN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= state == S_TURN && abort_q;
      if (state != S_DATA || !bus.trdy_n)
        wait_q <= '0;
      else if (!abort_q)
        wait_q <= wait_q + 1'b1;
      if (state == S_TURN)
        abort_q <= 1'b0;
      else if (state == S_DATA && bus.trdy_n
               && !abort_q
               && wait_q == WT_W'(TIMEOUT - 1))
        abort_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign abort_q = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_pci_master_if.sv
// Bench for pci_master_if: bus-phase model checked every cycle
// plus directed bursts with hand-computed expectations.
`timescale 1ns/1ps
module tb_pci_master_if;
  import pci_pkg::*;

  localparam int TMO = 16;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_ADDR = 2;
  localparam int P_DATA = 3;
  localparam int P_TURN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cmd = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  len = 4'h0;
  logic [31:0] wr_data = 32'h0;
  logic        data_ack;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        err;

  pci_master_if_if bus();

  pci_master_if #(
    .MAX_LEN(8),
    .LEN_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cmd(cmd),
    .addr(addr),
    .len(len),
    .wr_data(wr_data),
    .data_ack(data_ack),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .busy(busy),
    .done(done),
    .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endfunction

  // bus-phase model
  int          m_ph = P_IDLE;
  int          m_left = 0;
  int          m_nack = 0;
  int          m_wait = 0;
  logic        m_wr = 0;
  logic        m_abort = 0;
  logic        m_ack = 0;
  logic        m_rdv = 0;
  logic        m_done = 0;
  logic        m_err = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_rdd = 0;
  logic [3:0]  m_cmd = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= P_IDLE; m_left <= 0;
      m_nack <= 0; m_wait <= 0;
      m_abort <= 0; m_ack <= 0;
      m_rdv <= 0; m_done <= 0;
      m_err <= 0; m_rdd <= 0;
    end else begin
      m_ack <= 0; m_rdv <= 0;
      m_done <= 0; m_err <= 0;
      case (m_ph)
        P_IDLE: if (start) begin
          m_ph <= P_REQ;
          m_cmd <= cmd; m_addr <= addr;
          m_wr <= cmd[0];
          m_nack <= 0; m_abort <= 0;
          if (len == 0)     m_left <= 1;
          else if (len > 8) m_left <= 8;
          else              m_left <= int'(len);
        end
        P_REQ:
          if (!bus.gnt_n && bus.frame_in_n
              && bus.irdy_in_n)
            m_ph <= P_ADDR;
        P_ADDR: begin
          m_ph <= P_DATA; m_wait <= 0;
        end
        P_DATA:
          if (m_abort) m_ph <= P_TURN;
          else if (!bus.trdy_n) begin
            m_ack <= 1;
            m_rdv <= !m_wr;
            if (!m_wr) m_rdd <= bus.ad_in;
            m_nack <= m_nack + 1;
            m_left <= m_left - 1;
            m_wait <= 0;
            if (m_left == 1) m_ph <= P_TURN;
          end
`ifdef PCI_MASTER_TIMEOUT_EN
          else begin
            m_wait <= m_wait + 1;
            if (m_wait + 1 == TMO) m_abort <= 1;
          end
`endif
        P_TURN: begin
          m_ph <= P_IDLE; m_done <= 1;
          m_err <= m_abort; m_abort <= 0;
        end
        default: m_ph <= P_IDLE;
      endcase
    end
  end

  // local engine: write data for phase k is 5A5A_0000+k
  always @(posedge clk) begin
    #1;
    wr_data = 32'h5A5A_0000 + 32'(m_nack);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic e_fn, e_adoe, e_cboe;
      logic [31:0] e_ad;
      e_fn = !(m_ph == P_ADDR ||
               (m_ph == P_DATA && m_left > 1
                && !m_abort));
      e_adoe = m_ph == P_ADDR ||
               (m_ph == P_DATA && m_wr);
      e_cboe = m_ph == P_ADDR || m_ph == P_DATA;
      e_ad = (m_ph == P_ADDR) ? m_addr
           : 32'h5A5A_0000 + 32'(m_nack);
      chk("req_n", 32'(bus.req_n),
          32'(m_ph != P_REQ));
      chk("frame_n", 32'(bus.frame_n), 32'(e_fn));
      chk("frame_oe", 32'(bus.frame_oe),
          32'(m_ph == P_ADDR || m_ph == P_DATA));
      chk("irdy_n", 32'(bus.irdy_n),
          32'(m_ph != P_DATA));
      chk("irdy_oe", 32'(bus.irdy_oe),
          32'(m_ph >= P_ADDR));
      chk("ad_oe", 32'(bus.ad_oe), 32'(e_adoe));
      if (e_adoe) chk("ad_out", bus.ad_out, e_ad);
      chk("cbe_oe", 32'(bus.cbe_oe), 32'(e_cboe));
      if (e_cboe)
        chk("cbe_n", 32'(bus.cbe_n),
            (m_ph == P_ADDR) ? 32'(m_cmd) : 32'h0);
      chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("data_ack", 32'(data_ack), 32'(m_ack));
      chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      chk("rd_data", rd_data, m_rdd);
    end
  end

  logic [31:0] rdq[$];
  logic [31:0] seen_ad;
  logic [3:0]  seen_cbe;

  task automatic run(
    input  logic [3:0]  c,
    input  logic [31:0] a,
    input  logic [3:0]  l,
    input  int tm, input int bb,
    input  int poke, input int budget,
    output int nack, output int nbusy,
    output int nreq, output int nlast,
    output bit dn, output bit er);
    nack = 0; nbusy = 0; nreq = 0; nlast = 0;
    dn = 0; er = 0;
    rdq.delete();
    seen_ad = '0; seen_cbe = '0;
    start = 1; cmd = c; addr = a; len = l;
    @(posedge clk); #2;
    start = 0;
    for (int i = 0; i < budget && !dn; i++) begin
      bus.trdy_n = (tm == 0) ? 1'b0
                 : (tm == 1) ? 1'(i % 2 == 0)
                 : 1'b1;
      bus.frame_in_n = 1'(i >= bb);
      bus.ad_in = 32'hC0DE_0000 + 32'(i);
      if (i == poke) begin
        start = 1; cmd = MEM_WRITE;
        addr = 32'hDEAD_0000; len = 4'd2;
      end else start = 0;
      @(negedge clk);
      if (busy) nbusy++;
      if (!bus.req_n) nreq++;
      if (!bus.irdy_n && bus.frame_n) nlast++;
      if (bus.frame_oe && !bus.frame_n
          && bus.irdy_n) begin
        seen_ad = bus.ad_out;
        seen_cbe = bus.cbe_n;
      end
      if (data_ack) nack++;
      if (rd_valid) rdq.push_back(rd_data);
      if (done) begin dn = 1; er = err; end
      @(posedge clk); #2;
    end
    start = 0;
    bus.trdy_n = 1; bus.frame_in_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack, nbusy, nreq, nlast;
    bit dn, er;
    bus.gnt_n = 0; bus.frame_in_n = 1;
    bus.irdy_in_n = 1; bus.trdy_n = 1;
    bus.ad_in = 0;
    #1 rst_n = 0;
    #1 cmp_en = 1;
    #1;
    chk("rst req/frame/irdy",
        32'({bus.req_n, bus.frame_n, bus.irdy_n}),
        32'h7);
    chk("rst oes", 32'({bus.frame_oe, bus.irdy_oe,
        bus.ad_oe, bus.cbe_oe}), 32'h0);
    chk("rst cbe_n", 32'(bus.cbe_n), 32'hF);
    chk("rst ad_out", bus.ad_out, 32'h0);
    chk("rst rd_data", rd_data, 32'h0);
    chk("rst pulses", 32'({busy, done, err,
        data_ack, rd_valid}), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;

    // write len=1, zero-wait target
    run(MEM_WRITE, 32'h1000_0000, 4'd1, 0, 0, -1,
        20, nack, nbusy, nreq, nlast, dn, er);
    chk("w1 addr", seen_ad, 32'h1000_0000);
    chk("w1 cbe", 32'(seen_cbe), 32'h7);
    chk("w1 acks", 32'(nack), 32'd1);
    chk("w1 cycles", 32'(nbusy), 32'd4);
    chk("w1 last", 32'(nlast), 32'd1);
    chk("w1 done", 32'(dn), 32'd1);

    // read len=4, TRDY# every other cycle, stray start
    run(MEM_READ, 32'h4000_0000, 4'd4, 1, 0, 4,
        30, nack, nbusy, nreq, nlast, dn, er);
    chk("r4 acks", 32'(nack), 32'd4);
    chk("r4 nrd", 32'(rdq.size()), 32'd4);
    if (rdq.size() == 4) begin
      chk("r4 d0", rdq[0], 32'hC0DE_0003);
      chk("r4 d1", rdq[1], 32'hC0DE_0005);
      chk("r4 d2", rdq[2], 32'hC0DE_0007);
      chk("r4 d3", rdq[3], 32'hC0DE_0009);
    end
    chk("r4 last", 32'(nlast), 32'd2);
    chk("r4 cycles", 32'(nbusy), 32'd11);

    // bus busy for 3 cycles
    run(MEM_WRITE, 32'h1100_0000, 4'd1, 0, 3, -1,
        20, nack, nbusy, nreq, nlast, dn, er);
    chk("bb req", 32'(nreq), 32'd4);
    chk("bb cycles", 32'(nbusy), 32'd7);

    // len clamp
    run(MEM_WRITE, 32'h1200_0000, 4'd0, 0, 0, -1,
        20, nack, nbusy, nreq, nlast, dn, er);
    chk("l0 acks", 32'(nack), 32'd1);
    run(MEM_READ, 32'h3000_0000, 4'd12, 0, 0, -1,
        30, nack, nbusy, nreq, nlast, dn, er);
    chk("l12 acks", 32'(nack), 32'd8);
    chk("l12 cycles", 32'(nbusy), 32'd11);
    if (rdq.size() == 8) begin
      chk("l12 first", rdq[0], 32'hC0DE_0002);
      chk("l12 last", rdq[7], 32'hC0DE_0009);
    end else chk("l12 nrd", 32'(rdq.size()), 32'd8);

    // reset mid-DATA of a 4-phase write
    start = 1; cmd = MEM_WRITE;
    addr = 32'h2000_0000; len = 4'd4;
    @(posedge clk); #2;
    start = 0; bus.trdy_n = 0;
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 0;
    #1;
    chk("mid oes", 32'({bus.frame_oe, bus.irdy_oe,
        bus.ad_oe, bus.cbe_oe}), 32'h0);
    chk("mid released",
        32'({bus.req_n, bus.frame_n, bus.irdy_n}),
        32'h7);
    bus.trdy_n = 1;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn = 1;
    end
    chk("mid no done", 32'(dn), 32'd0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #2;
    run(MEM_WRITE, 32'h2100_0000, 4'd2, 0, 0, -1,
        20, nack, nbusy, nreq, nlast, dn, er);
    chk("post acks", 32'(nack), 32'd2);
    chk("post done", 32'(dn), 32'd1);

    // target never asserts TRDY#
    run(MEM_READ, 32'h5000_0000, 4'd2, 2, 0, -1,
        40, nack, nbusy, nreq, nlast, dn, er);
`ifdef PCI_MASTER_TIMEOUT_EN
    chk("to done", 32'(dn), 32'd1);
    chk("to err", 32'(er), 32'd1);
    chk("to acks", 32'(nack), 32'd0);
    chk("to cycles", 32'(nbusy), 32'd20);
    chk("to last", 32'(nlast), 32'd1);
`else
    chk("hang done", 32'(dn), 32'd0);
    chk("hang irdy", 32'({busy, bus.irdy_n}),
        32'h2);
    rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #2;
`endif

    repeat (2) @(posedge clk);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
